// File: rtl/spi_flash_emu_pkg.sv
// Shared definitions for the SPI flash emulator.
// Holds the recognised command codes, the controller state encoding and
// the default values of the top-level ADDR_OFFSET and JEDEC_ID parameters.
package spi_flash_emu_pkg;

  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [7:0]  CMD_JEDEC = 8'h9F;

  localparam logic [23:0] DEFAULT_ADDR_OFFSET = 24'h100000;
  localparam logic [23:0] DEFAULT_JEDEC_ID    = 24'hEF4018;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_ID     = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with rise/fall detection for one asynchronous input.
// Ports:
//   clk, rstn  : clock and synchronous active-low reset
//   din        : asynchronous input
//   sync       : synchronized level
//   rise, fall : single-cycle pulses on synchronized level changes
// Flops reset to RESET_VAL (the idle bus level). Edge pulses stay masked
// until the pipeline holds only post-reset samples, so the step from the
// reset value to the real pin level is never reported as an edge.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic [1:0] fill_q;
  logic       primed;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
      fill_q <= 2'd0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
      if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
    end
  end

  assign primed = (fill_q == 2'd3);
  assign sync   = sync_q;
  assign rise   = primed &  sync_q & ~prev_q;
  assign fall   = primed & ~sync_q &  prev_q;

endmodule

// File: rtl/spi_flash_emu.sv
// SPI (mode 0) read-only flash emulator backed by a byte-wide fetch port.
// Ports:
//   clk, rstn            : clock, synchronous active-low reset
//   spi_sclk/csb/d0      : host SPI inputs (asynchronous to clk)
//   spi_d1, spi_d1_oe    : MISO data and its output enable
//   mem_req, mem_addr    : single-cycle fetch request and its address
//   mem_data, mem_valid  : single-cycle fetch response
//   underrun             : sticky, a byte was due before its fetch returned
//   dbg_state            : current controller state (state_t encoding)
// Fetch handshake: mem_req pulses one cycle with mem_addr; the memory answers
// with exactly one mem_valid pulse carrying mem_data. Responses arriving with
// no request outstanding (e.g. after chip select rose) are dropped.
module spi_flash_emu
  import spi_flash_emu_pkg::*;
#(
  parameter logic [23:0] ADDR_OFFSET = DEFAULT_ADDR_OFFSET,
  parameter logic [23:0] JEDEC_ID    = DEFAULT_JEDEC_ID
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        spi_sclk,
  input  logic        spi_csb,
  input  logic        spi_d0,
  output logic        spi_d1,
  output logic        spi_d1_oe,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        mem_valid,
  output logic        underrun,
  output logic [2:0]  dbg_state
);

  logic unused_sclk_sync, sclk_rise, sclk_fall;
  logic csb_sync, csb_rise, csb_fall;
  logic d0_sync, unused_d0_rise, unused_d0_fall;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rstn(rstn), .din(spi_sclk),
    .sync(unused_sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_csb (
    .clk(clk), .rstn(rstn), .din(spi_csb),
    .sync(csb_sync), .rise(csb_rise), .fall(csb_fall)
  );
  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_d0 (
    .clk(clk), .rstn(rstn), .din(spi_d0),
    .sync(d0_sync), .rise(unused_d0_rise), .fall(unused_d0_fall)
  );

  state_t      state, state_nxt;
  logic [4:0]  bit_cnt;
  logic [23:0] shift_in;
  logic [7:0]  shift_out;
  logic [2:0]  out_cnt;
  logic [1:0]  id_idx;
  logic        d1_q;
  logic        pending;
  logic        have_byte;
  logic [7:0]  fetched;
  logic [23:0] rx_word;
  logic        shifting;
  logic [7:0]  load_byte;
  logic        load_empty;

  // Shift register contents including the bit sampled on this rise.
  assign rx_word   = {shift_in[22:0], d0_sync};
  assign shifting  = (state == ST_DATA) || (state == ST_ID);
  assign spi_d1    = d1_q;
  assign spi_d1_oe = shifting && !csb_sync;
  assign dbg_state = state;

  // Byte to present at the next byte boundary. A response landing in the
  // same cycle as the load is taken directly from mem_data.
  always_comb begin
    load_byte  = 8'hFF;
    load_empty = 1'b0;
    if (state == ST_ID) begin
      case (id_idx)
        2'd0:    load_byte = JEDEC_ID[23:16];
        2'd1:    load_byte = JEDEC_ID[15:8];
        2'd2:    load_byte = JEDEC_ID[7:0];
        default: load_byte = 8'hFF;
      endcase
    end else if (have_byte) begin
      load_byte = fetched;
    end else if (mem_valid && pending) begin
      load_byte = mem_data;
    end else begin
      load_empty = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (csb_rise) begin
      state_nxt = ST_IDLE;
    end else if (csb_fall) begin
      state_nxt = ST_CMD;
    end else begin
      case (state)
        ST_CMD:
          if (sclk_rise && bit_cnt == 5'd7) begin
            case (rx_word[7:0])
              CMD_READ:  state_nxt = ST_ADDR;
              CMD_JEDEC: state_nxt = ST_ID;
              default:   state_nxt = ST_IGNORE;
            endcase
          end
        ST_ADDR:
          if (sclk_rise && bit_cnt == 5'd23) state_nxt = ST_DATA;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bit_cnt   <= 5'd0;
      shift_in  <= 24'd0;
      shift_out <= 8'd0;
      out_cnt   <= 3'd0;
      id_idx    <= 2'd0;
      d1_q      <= 1'b1;
      pending   <= 1'b0;
      have_byte <= 1'b0;
      fetched   <= 8'd0;
      mem_req   <= 1'b0;
      mem_addr  <= 24'd0;
      underrun  <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      if (csb_rise || csb_fall) begin
        // Either edge ends the current transaction; dropping 'pending'
        // discards any fetch still in flight.
        bit_cnt   <= 5'd0;
        shift_in  <= 24'd0;
        shift_out <= 8'd0;
        out_cnt   <= 3'd0;
        id_idx    <= 2'd0;
        d1_q      <= 1'b1;
        pending   <= 1'b0;
        have_byte <= 1'b0;
      end else begin
        if (mem_valid && pending) begin
          fetched   <= mem_data;
          have_byte <= 1'b1;
          pending   <= 1'b0;
        end
        if (sclk_rise && (state == ST_CMD || state == ST_ADDR)) begin
          shift_in <= rx_word;
          if ((state == ST_CMD && bit_cnt == 5'd7) || (state == ST_ADDR && bit_cnt == 5'd23))
            bit_cnt <= 5'd0;
          else
            bit_cnt <= bit_cnt + 5'd1;
          if (state == ST_ADDR && bit_cnt == 5'd23) begin
            mem_req   <= 1'b1;
            mem_addr  <= rx_word + ADDR_OFFSET;
            pending   <= 1'b1;
            have_byte <= 1'b0;
          end
        end
        if (sclk_fall && shifting) begin
          out_cnt <= out_cnt + 3'd1;
          if (out_cnt == 3'd0) begin
            // Byte boundary: the MSB goes straight out, the rest is queued.
            d1_q      <= load_byte[7];
            shift_out <= {load_byte[6:0], 1'b1};
            if (state == ST_ID) begin
              if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
            end else begin
              mem_req   <= 1'b1;
              mem_addr  <= mem_addr + 24'd1;
              pending   <= 1'b1;
              have_byte <= 1'b0;
              if (load_empty) underrun <= 1'b1;
            end
          end else begin
            d1_q      <= shift_out[7];
            shift_out <= {shift_out[6:0], 1'b1};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_emu.sv
module tb_spi_flash_emu;
  import spi_flash_emu_pkg::*;

  localparam int          HALF = 80;           // sclk half period: 8 clk cycles
  localparam logic [23:0] OFF  = 24'h100000;
  localparam logic [23:0] JID  = 24'hEF4018;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_csb = 1'b1;
  logic        spi_d0 = 1'b0;
  logic [7:0]  mem_data = 8'd0;
  logic        mem_valid = 1'b0;
  logic        spi_d1, spi_d1_oe, mem_req, underrun;
  logic [23:0] mem_addr;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  spi_flash_emu dut (
    .clk(clk), .rstn(rstn),
    .spi_sclk(spi_sclk), .spi_csb(spi_csb), .spi_d0(spi_d0),
    .spi_d1(spi_d1), .spi_d1_oe(spi_d1_oe),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_valid(mem_valid),
    .underrun(underrun), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  exp_q[$];
  logic [23:0] obs_addr[$];
  int          oe_cnt   = 0;
  int          mem_mode = 0;   // 0 normal, 1 never answer, 2 answer late with stale data

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) if (spi_d1_oe === 1'b1) oe_cnt <= oe_cnt + 1;

  // Memory model: records every request, answers according to mem_mode.
  initial begin
    logic [23:0] a;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        a = mem_addr;
        obs_addr.push_back(a);
        if (mem_mode == 0) begin
          @(posedge clk); #1;
          mem_data = a[7:0]; mem_valid = 1'b1;
          @(posedge clk); #1 mem_valid = 1'b0;
        end else if (mem_mode == 2) begin
          while (spi_csb !== 1'b1) @(posedge clk);
          repeat (4) @(posedge clk);
          #1 mem_data = 8'hA5; mem_valid = 1'b1;
          @(posedge clk); #1 mem_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [23:0] eff_addr(input logic [23:0] a, input int k);
    return 24'(a + OFF + 24'(k));
  endfunction

  function automatic logic [7:0] jedec_byte(input int k);
    logic [23:0] v;
    if (k > 2) return 8'hFF;
    v = JID >> (8 * (2 - k));
    return v[7:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic reset_dut(input string tag);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_state"},  dbg_state, ST_IDLE);
    check({tag, "_d1"},     spi_d1, 1'b1);
    check({tag, "_oe"},     spi_d1_oe, 1'b0);
    check({tag, "_req"},    mem_req, 1'b0);
    check({tag, "_addr"},   mem_addr, 24'd0);
    check({tag, "_undrun"}, underrun, 1'b0);
    #1 rstn = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic spi_bit(input logic b, output logic r);
    spi_d0 = b;
    #(HALF);
    r = spi_d1;
    spi_sclk = 1'b1;
    #(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_bits(input logic [23:0] v, input int n);
    logic r;
    for (int i = n - 1; i >= 0; i--) spi_bit(v[i], r);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic [7:0] r;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      r[i] = b;
    end
    rx = r;
  endtask

  task automatic spi_start();
    spi_csb = 1'b0;
    #(HALF);
  endtask

  task automatic spi_end();
    #(HALF);
    spi_csb = 1'b1;
    repeat (24) @(posedge clk);
    #2;
  endtask

  // ---------------- transactions ----------------
  task automatic do_read(input logic [23:0] a, input int n, input string tag);
    logic [7:0] rx, e;
    logic [23:0] ea;
    int base, oe0;
    base = obs_addr.size();
    oe0  = oe_cnt;
    spi_start();
    spi_bits({16'd0, CMD_READ}, 8);
    spi_bits(a, 24);
    for (int k = 0; k < n; k++) begin
      ea = eff_addr(a, k);
      exp_q.push_back((mem_mode == 1) ? 8'hFF : ea[7:0]);
      spi_byte(8'($urandom), rx);
      e = exp_q.pop_front();
      check($sformatf("%s_byte%0d", tag, k), rx, e);
    end
    check({tag, "_in_data"}, dbg_state, ST_DATA);
    spi_end();
    check({tag, "_nreq"}, obs_addr.size() - base, n + 2);
    for (int k = 0; k < n + 2 && base + k < obs_addr.size(); k++)
      check($sformatf("%s_addr%0d", tag, k), obs_addr[base + k], eff_addr(a, k));
    check({tag, "_oe_seen"}, (oe_cnt - oe0) > 0, 1'b1);
    check({tag, "_idle"}, dbg_state, ST_IDLE);
    check({tag, "_oe_off"}, spi_d1_oe, 1'b0);
  endtask

  task automatic do_jedec(input string tag);
    logic [7:0] rx;
    int base;
    base = obs_addr.size();
    spi_start();
    spi_bits({16'd0, CMD_JEDEC}, 8);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(jedec_byte(k));
      spi_byte(8'($urandom), rx);
      check($sformatf("%s_byte%0d", tag, k), rx, exp_q.pop_front());
    end
    check({tag, "_in_id"}, dbg_state, ST_ID);
    spi_end();
    check({tag, "_noreq"}, obs_addr.size() - base, 0);
    check({tag, "_idle"}, dbg_state, ST_IDLE);
  endtask

  task automatic do_unknown(input logic [7:0] cmd, input string tag);
    logic [7:0] rx;
    int oe0, base;
    oe0  = oe_cnt;
    base = obs_addr.size();
    spi_start();
    spi_bits({16'd0, cmd}, 8);
    for (int k = 0; k < 2; k++) begin
      spi_byte(8'($urandom), rx);
      check($sformatf("%s_byte%0d", tag, k), rx, 8'hFF);
    end
    check({tag, "_ignore"}, dbg_state, ST_IGNORE);
    spi_end();
    check({tag, "_oe_never"}, oe_cnt - oe0, 0);
    check({tag, "_noreq"}, obs_addr.size() - base, 0);
    check({tag, "_idle"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]  cmd;
    logic [23:0] a;
    int base, oe0;

    reset_dut("reset");

    do_read(24'h000010, 4, "read");
    check("read_underrun", underrun, 1'b0);
    do_read(24'hEFFFFF, 2, "wrap");
    do_jedec("jedec");
    do_unknown(8'h05, "unknown");

    for (int t = 0; t < 6; t++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          a = (t % 2 == 0) ? 24'($urandom) : 24'hEFFFF0 + 24'($urandom_range(0, 15));
          do_read(a, $urandom_range(1, 3), $sformatf("rnd%0d_read", t));
        end
        2: do_jedec($sformatf("rnd%0d_jedec", t));
        default: begin
          do cmd = 8'($urandom); while (cmd == CMD_READ || cmd == CMD_JEDEC);
          do_unknown(cmd, $sformatf("rnd%0d_unk", t));
        end
      endcase
    end
    check("rnd_underrun", underrun, 1'b0);

    // Abort after 4 data bits; the memory answers only after csb is high.
    mem_mode = 2;
    spi_start();
    spi_bits({16'd0, CMD_READ}, 8);
    spi_bits(24'h000000, 24);
    spi_bits(24'h0, 4);
    spi_end();
    repeat (20) @(posedge clk);
    #2;
    check("abort_idle", dbg_state, ST_IDLE);
    mem_mode = 0;
    do_read(24'h000000, 2, "after_abort");

    // Reset pulsed in the middle of the address phase.
    base = obs_addr.size();
    spi_start();
    spi_bits({16'd0, CMD_READ}, 8);
    spi_bits(24'h000ABC, 12);
    reset_dut("rst_mid");
    oe0 = oe_cnt;
    spi_bits(24'h000ABC, 12);
    spi_bits(24'h0000FF, 8);
    check("rst_mid_idle", dbg_state, ST_IDLE);
    spi_end();
    check("rst_mid_noreq", obs_addr.size() - base, 0);
    check("rst_mid_oe_never", oe_cnt - oe0, 0);
    do_read(24'h000000, 2, "after_rst");
    check("after_rst_underrun", underrun, 1'b0);

    // Underrun: memory never answers, then sticky until reset.
    mem_mode = 1;
    do_read(24'($urandom), 1, "undrun");
    check("undrun_flag", underrun, 1'b1);
    mem_mode = 0;
    do_read(24'($urandom), 2, "sticky");
    check("sticky_flag", underrun, 1'b1);
    reset_dut("clear");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_emu.md
SPI_FLASH_EMU -- requirements
Module: spi_flash_emu

Interface
REQ-001 Parameter ADDR_OFFSET, default 24'h100000, SHALL be added modulo 2^24 to every received read address.
REQ-002 Parameter JEDEC_ID, default 24'hEF4018, SHALL be the ID returned for command 0x9F, MSB first.
REQ-003 clk  in  1  sole clock; all logic SHALL be synchronous to its rising edge.
REQ-004 rstn  in  1  synchronous, active-low reset.
REQ-005 spi_sclk  in  1  SPI clock from the host, mode 0, asynchronous to clk.
REQ-006 spi_csb  in  1  active-low chip select from the host, asynchronous.
REQ-007 spi_d0  in  1  host-to-device data (MOSI), asynchronous.
REQ-008 spi_d1  out  1  device-to-host data (MISO).
REQ-009 spi_d1_oe  out  1  output enable for spi_d1.
REQ-010 mem_req  out  1  single-cycle byte fetch request.
REQ-011 mem_addr  out  24  fetch address, valid while mem_req is high.
REQ-012 mem_data  in  8  fetched byte, valid while mem_valid is high.
REQ-013 mem_valid  in  1  single-cycle response strobe.
REQ-014 underrun  out  1  sticky flag: a data byte was needed before mem_valid arrived.

Function
REQ-015 spi_sclk, spi_csb and spi_d0 SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized sclk.
REQ-016 Supported host rate SHALL be f(sclk) <= f(clk)/12; mem_valid SHALL be required within 2 clk of mem_req.
REQ-017 spi_d0 SHALL be sampled on each detected sclk rise; spi_d1 SHALL update on each detected sclk fall; bit order MSB first.
REQ-018 FSM states: IDLE, CMD, ADDR, DATA, ID, IGNORE.
REQ-019 IDLE -> CMD on synchronized csb falling; bit counter cleared.
REQ-020 CMD: after 8 rises, 0x03 -> ADDR, 0x9F -> ID, any other value -> IGNORE.
REQ-021 ADDR: after 24 rises, mem_req SHALL pulse on the next clk with mem_addr = received address + ADDR_OFFSET; -> DATA.
REQ-022 DATA: the fetched byte SHALL load into the shift register on the first sclk fall after its mem_valid; each loaded byte SHALL trigger the next mem_req with mem_addr incremented by 1, wrapping 24'hFFFFFF -> 24'h000000.
REQ-023 If a byte load is due and no mem_valid has arrived since the last request, 8'hFF SHALL be shifted instead and underrun SHALL be set.
REQ-024 ID: the three JEDEC_ID bytes SHALL be shifted in sequence, after which 8'hFF SHALL be repeated; no mem_req SHALL occur.
REQ-025 IGNORE: spi_d1_oe SHALL be low, spi_d1 SHALL be 1, and the FSM SHALL remain in IGNORE until csb rises.
REQ-026 spi_d1_oe SHALL be high only in DATA or ID while synchronized csb is low.
REQ-027 Synchronized csb rising in any state SHALL force IDLE on the next clk, and any outstanding mem_valid SHALL be discarded.
REQ-028 csb falling while not in IDLE SHALL restart at CMD with counters cleared.
REQ-029 underrun SHALL be cleared only by reset.

Reset
REQ-030 With rstn low at a clk edge, the FSM SHALL be IDLE, all counters and shift registers zero, spi_d1 = 1, spi_d1_oe = 0, mem_req = 0, mem_addr = 0, and underrun = 0.
REQ-031 Synchronizer flops SHALL reset to the idle bus levels: sclk 0, csb 1, d0 0.
REQ-032 Reset asserted mid-transaction SHALL abort it; after reset the block SHALL ignore the transaction until the next csb falling.

Structure
REQ-033 Shared package SHALL hold the command codes (0x03, 0x9F), the FSM state enum, and the default values of ADDR_OFFSET and JEDEC_ID.
REQ-034 One sub-module spi_sync_edge SHALL provide the 2-flop synchronizer plus rise/fall edge detection; all other logic SHALL be inline.

Verification
REQ-035 Read: 03 00 00 10, memory model returns addr[7:0] at 1 clk latency -> mem_addr 0x100010, 0x100011, ...; MISO shows 10 11 12 13; underrun = 0.
REQ-036 Wrap: 03 FF FF FF with offset 0 -> mem_addr FFFFFF then 000000; MISO shows FF 00.
REQ-037 JEDEC: 9F followed by 4 dummy bytes -> MISO EF 40 18 FF; mem_req never asserted.
REQ-038 Unknown command: 0x05, then 2 bytes -> spi_d1_oe stays 0; FSM returns to IDLE at csb high.
REQ-039 Underrun: memory model never asserts mem_valid -> first data byte FF and underrun = 1 until rstn.
REQ-040 Abort: csb raised after 4 data bits, late mem_valid injected, then a new read 03 000000 -> first byte is correct and not stale; apply the same check with rstn pulsed mid-ADDR.
